// File: rtl/i2s_master_stereo_pkg.sv
// Shared constants and parameter legality check for the stereo I2S transmitter.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package i2s_master_stereo_pkg;

    localparam int MODE_I2S = 0;
    localparam int MODE_LJ  = 1;

    // Elaboration-time sanity check of the parameter set.
    function automatic bit i2s_params_ok(input int smp_w, input int slot_w,
                                         input int bck_div, input int mclk_div,
                                         input int mode);
        return (smp_w >= 1) && (smp_w <= slot_w)
            && (bck_div >= 2) && (bck_div % 2 == 0)
            && (mclk_div >= 2) && (mclk_div % 2 == 0)
            && (bck_div % mclk_div == 0)
            && ((mode == MODE_I2S) || (mode == MODE_LJ));
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Counter-based generator for SCK/BCK/LCK plus tick and frame-start strobes.
// Latency: clock outputs are registered one CLK behind the counter state.
// Backpressure: none; free-running once out of reset.
module i2s_clkgen #(
    parameter int SLOT_W   = 32,
    parameter int BCK_DIV  = 4,
    parameter int MCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic run,
    output logic tick,
    output logic frame_start,
    output logic sck,
    output logic bck,
    output logic lck
);

    localparam int CW = $clog2(BCK_DIV);
    localparam int BW = $clog2(2 * SLOT_W);
    localparam int MW = $clog2(MCLK_DIV);

    localparam logic [CW-1:0] C_MAX  = CW'(BCK_DIV - 1);
    localparam logic [CW-1:0] C_HALF = CW'(BCK_DIV / 2);
    localparam logic [BW-1:0] B_MAX  = BW'(2 * SLOT_W - 1);
    localparam logic [BW-1:0] B_HALF = BW'(SLOT_W);
    localparam logic [MW-1:0] M_MAX  = MW'(MCLK_DIV - 1);
    localparam logic [MW-1:0] M_HALF = MW'(MCLK_DIV / 2);

    logic [CW-1:0] c_q, c_d;
    logic [BW-1:0] b_q, b_d;
    logic [MW-1:0] m_q, m_d;
    logic          run_q, run_d;
    logic          sck_q, sck_d;
    logic          bck_q, bck_d;
    logic          lck_q, lck_d;

    // Counter advance and clock-level decode; counters hold until the first edge after reset.
    always_comb begin
        c_d   = c_q;
        b_d   = b_q;
        m_d   = m_q;
        run_d = 1'b1;
        if (run_q) begin
            m_d = (m_q == M_MAX) ? '0 : m_q + MW'(1);
            if (c_q == C_MAX) begin
                c_d = '0;
                b_d = (b_q == B_MAX) ? '0 : b_q + BW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
        end
        sck_d = (m_q >= M_HALF);
        bck_d = (c_q >= C_HALF);
        lck_d = (b_q >= B_HALF);
    end

    // State and clock output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q   <= '0;
            b_q   <= '0;
            m_q   <= '0;
            run_q <= 1'b0;
            sck_q <= 1'b0;
            bck_q <= 1'b0;
            lck_q <= 1'b0;
        end else begin
            c_q   <= c_d;
            b_q   <= b_d;
            m_q   <= m_d;
            run_q <= run_d;
            sck_q <= sck_d;
            bck_q <= bck_d;
            lck_q <= lck_d;
        end
    end

    assign run         = run_q;
    assign tick        = run_q && (c_q == '0);
    assign frame_start = tick && (b_q == '0);
    assign sck         = sck_q;
    assign bck         = bck_q;
    assign lck         = lck_q;

endmodule

// File: rtl/i2s_master_stereo.sv
// Stereo I2S / left-justified transmitter with a one-deep L/R holding buffer.
// Latency: a buffered pair goes out in the next frame; DIN is one BCK later in I2S mode.
// Backpressure: SMP_READY low while the buffer holds a pair; empty frames repeat the last pair.
module i2s_master_stereo
    import i2s_master_stereo_pkg::*;
#(
    parameter int SMP_W    = 16,
    parameter int SLOT_W   = 32,
    parameter int BCK_DIV  = 4,
    parameter int MCLK_DIV = 2,
    parameter int MODE     = 0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [SMP_W-1:0] L_SMP,
    input  logic [SMP_W-1:0] R_SMP,
    input  logic             SMP_VALID,
    output logic             SMP_READY,
    output logic             SCK,
    output logic             BCK,
    output logic             LCK,
    output logic             DIN,
    output logic             FRAME,
    output logic             UNDERRUN
);

    localparam int SR_W  = 2 * SLOT_W;
    localparam int PAD_W = SLOT_W - SMP_W;

    generate
        if (!i2s_params_ok(SMP_W, SLOT_W, BCK_DIV, MCLK_DIV, MODE)) begin : g_bad_params
            $error("i2s_master_stereo: illegal parameter combination");
        end
    endgenerate

    logic run, tick, frame_start;

    i2s_clkgen #(
        .SLOT_W   (SLOT_W),
        .BCK_DIV  (BCK_DIV),
        .MCLK_DIV (MCLK_DIV)
    ) u_clkgen (
        .clk         (CLK),
        .rst_n       (RESET_N),
        .run         (run),
        .tick        (tick),
        .frame_start (frame_start),
        .sck         (SCK),
        .bck         (BCK),
        .lck         (LCK)
    );

    logic             full_q, full_d;
    logic [SMP_W-1:0] buf_l_q, buf_l_d;
    logic [SMP_W-1:0] buf_r_q, buf_r_d;
    logic [SR_W-1:0]  shift_q, shift_d;
    logic             dly_q, dly_d;
    logic [SLOT_W-1:0] l_slot, r_slot;
    logic             xfer;

    // Samples sit MSB-aligned in their slot; buffer contents double as the last-sample hold.
    assign l_slot = SLOT_W'(buf_l_q) << PAD_W;
    assign r_slot = SLOT_W'(buf_r_q) << PAD_W;

    assign SMP_READY = run && !full_q;
    assign xfer      = SMP_VALID && SMP_READY;

    // Buffer handshake, frame load / shift, and I2S one-bit delay.
    always_comb begin
        full_d  = full_q;
        buf_l_d = buf_l_q;
        buf_r_d = buf_r_q;
        shift_d = shift_q;
        dly_d   = dly_q;
        if (tick) begin
            dly_d = shift_q[SR_W-1];
            if (frame_start) begin
                shift_d = {l_slot, r_slot};
            end else begin
                shift_d = {shift_q[SR_W-2:0], 1'b0};
            end
        end
        if (frame_start) begin
            full_d = 1'b0;
        end
        // A transfer on the frame-start cycle is stored after the load took the old pair.
        if (xfer) begin
            buf_l_d = L_SMP;
            buf_r_d = R_SMP;
            full_d  = 1'b1;
        end
    end

    // Datapath flops.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            full_q  <= 1'b0;
            buf_l_q <= '0;
            buf_r_q <= '0;
            shift_q <= '0;
            dly_q   <= 1'b0;
        end else begin
            full_q  <= full_d;
            buf_l_q <= buf_l_d;
            buf_r_q <= buf_r_d;
            shift_q <= shift_d;
            dly_q   <= dly_d;
        end
    end

    assign DIN      = (MODE == MODE_LJ) ? shift_q[SR_W-1] : dly_q;
    assign FRAME    = frame_start;
    assign UNDERRUN = frame_start && !full_q;

endmodule

// File: tb/tb_i2s_master_stereo.sv
module tb_i2s_master_stereo;

    logic        clk;
    logic        rst_n;
    logic [15:0] l_smp;
    logic [15:0] r_smp;
    logic        smp_valid;

    logic rdy0, sck0, bck0, lck0, din0, frm0, und0;
    logic rdy1, sck1, bck1, lck1, din1, frm1, und1;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] PAIR_LJ  = 64'h8001_0000_7FFE_0000;
    localparam logic [63:0] PAIR_I2S = 64'h4000_8000_3FFF_0000;

    i2s_master_stereo #(
        .SMP_W(16), .SLOT_W(32), .BCK_DIV(4), .MCLK_DIV(2), .MODE(0)
    ) dut_i2s (
        .CLK(clk), .RESET_N(rst_n), .L_SMP(l_smp), .R_SMP(r_smp),
        .SMP_VALID(smp_valid), .SMP_READY(rdy0), .SCK(sck0), .BCK(bck0),
        .LCK(lck0), .DIN(din0), .FRAME(frm0), .UNDERRUN(und0)
    );

    i2s_master_stereo #(
        .SMP_W(16), .SLOT_W(32), .BCK_DIV(4), .MCLK_DIV(2), .MODE(1)
    ) dut_lj (
        .CLK(clk), .RESET_N(rst_n), .L_SMP(l_smp), .R_SMP(r_smp),
        .SMP_VALID(smp_valid), .SMP_READY(rdy1), .SCK(sck1), .BCK(bck1),
        .LCK(lck1), .DIN(din1), .FRAME(frm1), .UNDERRUN(und1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next negedge on which FRAME is high (returns at once if already there).
    task automatic wait_frame();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (frm0 === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_frame: FRAME got 0 within 300 cycles, need 1");
        end
    endtask

    // Starting on a frame-start negedge, record DIN mid-BCK for b=0..63 (bit 63 = b0).
    task automatic capture_frame(output logic [63:0] lj, output logic [63:0] i2s);
        lj  = '0;
        i2s = '0;
        for (int n = 0; n < 256; n++) begin
            if (n % 4 == 2) begin
                lj[63 - n / 4]  = din1;
                i2s[63 - n / 4] = din0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        smp_valid = 1'b0;
        l_smp     = '0;
        r_smp     = '0;
        @(negedge clk);
        checks++;
        if ({sck0, bck0, lck0, din0, frm0, und0, rdy0} !== 7'b0) begin
            errors++;
            $display("FAIL reset_out_i2s: got %b need 0000000", {sck0, bck0, lck0, din0, frm0, und0, rdy0});
        end
        checks++;
        if ({sck1, bck1, lck1, din1, frm1, und1, rdy1} !== 7'b0) begin
            errors++;
            $display("FAIL reset_out_lj: got %b need 0000000", {sck1, bck1, lck1, din1, frm1, und1, rdy1});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy0, frm0, und0} !== 3'b111) begin
            errors++;
            $display("FAIL release_i2s rdy/frame/underrun: got %b need 111", {rdy0, frm0, und0});
        end
        checks++;
        if ({rdy1, frm1, und1} !== 3'b111) begin
            errors++;
            $display("FAIL release_lj rdy/frame/underrun: got %b need 111", {rdy1, frm1, und1});
        end
    endtask

    task automatic test_idle_clocks();
        int bad_sck, bad_bck, bad_lck, bad_frm, bad_und, bad_din, lck_hi;
        logic e_sck, e_bck, e_lck, e_frm;
        bad_sck = 0; bad_bck = 0; bad_lck = 0; bad_frm = 0; bad_und = 0; bad_din = 0; lck_hi = 0;
        @(negedge clk);
        wait_frame();
        for (int n = 0; n < 512; n++) begin
            e_sck = ((n + 1) % 2) == 1;
            e_bck = ((n + 3) % 4) >= 2;
            e_lck = (((n + 255) % 256) / 4) >= 32;
            e_frm = (n % 256) == 0;
            if (sck0 !== e_sck || sck1 !== e_sck) bad_sck++;
            if (bck0 !== e_bck || bck1 !== e_bck) bad_bck++;
            if (lck0 !== e_lck || lck1 !== e_lck) bad_lck++;
            if (frm0 !== e_frm || frm1 !== e_frm) bad_frm++;
            if (und0 !== e_frm || und1 !== e_frm) bad_und++;
            if (din0 !== 1'b0 || din1 !== 1'b0) bad_din++;
            if (lck0 === 1'b1) lck_hi++;
            @(negedge clk);
        end
        checks++; if (bad_sck !== 0) begin errors++; $display("FAIL idle_sck: %0d bad cycles, need 0", bad_sck); end
        checks++; if (bad_bck !== 0) begin errors++; $display("FAIL idle_bck: %0d bad cycles, need 0", bad_bck); end
        checks++; if (bad_lck !== 0) begin errors++; $display("FAIL idle_lck: %0d bad cycles, need 0", bad_lck); end
        checks++; if (bad_frm !== 0) begin errors++; $display("FAIL idle_frame: %0d bad cycles, need 0", bad_frm); end
        checks++; if (bad_und !== 0) begin errors++; $display("FAIL idle_underrun: %0d bad cycles, need 0", bad_und); end
        checks++; if (bad_din !== 0) begin errors++; $display("FAIL idle_din: %0d bad cycles, need 0", bad_din); end
        checks++; if (lck_hi !== 256) begin errors++; $display("FAIL idle_lck_duty: high %0d of 512, need 256", lck_hi); end
    endtask

    task automatic test_bitstream();
        logic [63:0] lj, i2s;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL pair_ready_before: got %b need 1", rdy0); end
        l_smp = 16'h8001; r_smp = 16'h7FFE; smp_valid = 1'b1;
        @(negedge clk);
        smp_valid = 1'b0;
        checks++;
        if ({rdy0, rdy1} !== 2'b00) begin errors++; $display("FAIL pair_ready_after: got %b need 00", {rdy0, rdy1}); end
        wait_frame();
        checks++;
        if ({und0, und1} !== 2'b00) begin errors++; $display("FAIL pair_underrun: got %b need 00", {und0, und1}); end
        capture_frame(lj, i2s);
        checks++;
        if (lj !== PAIR_LJ) begin errors++; $display("FAIL lj_stream: got %h need %h", lj, PAIR_LJ); end
        checks++;
        if (i2s !== PAIR_I2S) begin errors++; $display("FAIL i2s_stream: got %h need %h", i2s, PAIR_I2S); end
    endtask

    task automatic test_underrun();
        logic [63:0] lj, i2s;
        for (int f = 0; f < 2; f++) begin
            wait_frame();
            checks++;
            if ({und0, und1} !== 2'b11) begin errors++; $display("FAIL underrun_pulse f%0d: got %b need 11", f, {und0, und1}); end
            capture_frame(lj, i2s);
            checks++;
            if (lj !== PAIR_LJ) begin errors++; $display("FAIL underrun_hold_lj f%0d: got %h need %h", f, lj, PAIR_LJ); end
            checks++;
            if (i2s !== PAIR_I2S) begin errors++; $display("FAIL underrun_hold_i2s f%0d: got %h need %h", f, i2s, PAIR_I2S); end
        end
    endtask

    task automatic test_back_to_back();
        int          xfer_cnt[3];
        int          rdy_off[3];
        logic        und_at[3];
        logic [63:0] cap[3];
        logic        pending;
        int          k, off;
        for (int i = 0; i < 3; i++) begin
            xfer_cnt[i] = 0; rdy_off[i] = -1; und_at[i] = 1'bx; cap[i] = '0;
        end
        wait_frame();
        // Valid goes high on the frame-start cycle itself, so the first pair must queue.
        l_smp = 16'h1230; r_smp = 16'hA5C0; smp_valid = 1'b1; pending = 1'b0;
        for (int n = 0; n < 768; n++) begin
            k   = n / 256;
            off = n % 256;
            if (pending) begin
                l_smp = l_smp + 16'd1;
                r_smp = r_smp + 16'd1;
            end
            pending = rdy0;
            if (rdy0 === 1'b1) begin
                xfer_cnt[k]++;
                rdy_off[k] = off;
            end
            if (off == 0) und_at[k] = und0;
            if (off % 4 == 2) cap[k][63 - off / 4] = din1;
            @(negedge clk);
        end
        smp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (xfer_cnt[i] !== 1) begin errors++; $display("FAIL b2b_xfers f%0d: got %0d need 1", i, xfer_cnt[i]); end
        end
        checks++; if (rdy_off[0] !== 0) begin errors++; $display("FAIL b2b_ready_off f0: got %0d need 0", rdy_off[0]); end
        checks++; if (rdy_off[1] !== 1) begin errors++; $display("FAIL b2b_ready_off f1: got %0d need 1", rdy_off[1]); end
        checks++; if (rdy_off[2] !== 1) begin errors++; $display("FAIL b2b_ready_off f2: got %0d need 1", rdy_off[2]); end
        checks++; if (und_at[0] !== 1'b1) begin errors++; $display("FAIL b2b_underrun f0: got %b need 1", und_at[0]); end
        checks++; if (und_at[1] !== 1'b0) begin errors++; $display("FAIL b2b_underrun f1: got %b need 0", und_at[1]); end
        checks++; if (und_at[2] !== 1'b0) begin errors++; $display("FAIL b2b_underrun f2: got %b need 0", und_at[2]); end
        checks++;
        if (cap[1] !== 64'h1230_0000_A5C0_0000) begin errors++; $display("FAIL b2b_queued_pair: got %h need 12300000a5c00000", cap[1]); end
        checks++;
        if (cap[2] !== 64'h1231_0000_A5C1_0000) begin errors++; $display("FAIL b2b_next_pair: got %h need 12310000a5c10000", cap[2]); end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] lj, i2s;
        wait_frame();
        for (int i = 0; i < 83; i++) @(negedge clk);
        checks++;
        if ({bck0, bck1, rdy0, rdy1} !== 4'b1111) begin
            errors++; $display("FAIL midframe_pre bck/ready: got %b need 1111", {bck0, bck1, rdy0, rdy1});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sck0, bck0, lck0, din0, frm0, und0, rdy0, sck1, bck1, lck1, din1, frm1, und1, rdy1} !== 14'b0) begin
            errors++;
            $display("FAIL midframe_async_reset: got %b need all 0",
                     {sck0, bck0, lck0, din0, frm0, und0, rdy0, sck1, bck1, lck1, din1, frm1, und1, rdy1});
        end
        @(negedge clk);
        checks++;
        if ({rdy0, rdy1, frm0, frm1} !== 4'b0) begin
            errors++; $display("FAIL midframe_held_reset: got %b need 0000", {rdy0, rdy1, frm0, frm1});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy0, frm0, und0, rdy1, frm1, und1} !== 6'b111111) begin
            errors++; $display("FAIL midframe_release: got %b need 111111", {rdy0, frm0, und0, rdy1, frm1, und1});
        end
        capture_frame(lj, i2s);
        checks++;
        if (lj !== 64'h0 || i2s !== 64'h0) begin
            errors++; $display("FAIL midframe_cleared_data: got lj %h i2s %h need 0", lj, i2s);
        end
    endtask

    initial begin
        test_reset();
        test_idle_clocks();
        test_bitstream();
        test_underrun();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

endmodule
